// File: rtl/irq_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt/trap controller:
// cause codes, FSM state encoding and the priority/mcause helpers.
package irq_trap_ctrl_pkg;

  localparam logic [3:0] IRQ_CODE_MSI   = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI   = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI   = 4'd11;
  localparam int         MCAUSE_INT_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  // Fixed priority MEI > MSI > MTI; the result is only meaningful when some input is set.
  function automatic logic [3:0] irq_pick(input logic p_mei, input logic p_msi,
                                          input logic p_mti);
    logic [3:0] code;
    code = IRQ_CODE_MTI;
    if (p_mei)      code = IRQ_CODE_MEI;
    else if (p_msi) code = IRQ_CODE_MSI;
    else if (p_mti) code = IRQ_CODE_MTI;
    return code;
  endfunction

  function automatic logic [31:0] mcause_of(input logic [3:0] code);
    logic [31:0] c;
    c                 = '0;
    c[MCAUSE_INT_BIT] = 1'b1;
    c[3:0]            = code;
    return c;
  endfunction

endpackage

// File: rtl/irq_trap_ctrl_sync.sv
// irq_sync: parameterised flop-chain synchroniser, reset to 0.
// Used by irq_trap_ctrl only when IRQ_SYNC_EN is defined.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: reset here is synchronous (sampled on clk), so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt arbiter: gates MSIP/MTIP/MEIP, issues one trap at a time
// with req/ack, and holds off after mret. Optional MEIP synchroniser: IRQ_SYNC_EN.
module irq_trap_ctrl
  import irq_trap_ctrl_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        irq_msip,
  input  logic        irq_mtip,
  input  logic        irq_meip,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic        instr_bound,
  input  logic        trap_ack,
  input  logic        mret,
  output logic [31:0] mip,
  output logic        trap_req,
  output logic [31:0] trap_cause,
  output logic        busy
);

  localparam int CW_RAW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? CW'(HOLDOFF_CYCLES - 1) : '0;

  logic w_meip;

`ifdef IRQ_SYNC_EN
  irq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_meip_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (irq_meip),
    .o_q    (w_meip)
  );
`else
  localparam int unused_sync_stages = SYNC_STAGES;
  assign w_meip = irq_meip;
`endif

  logic       w_pend_mei;
  logic       w_pend_msi;
  logic       w_pend_mti;
  logic       w_take;
  logic [3:0] w_code;
  logic       w_unused_mie;

  assign mip = {20'b0, w_meip, 3'b0, irq_mtip, 3'b0, irq_msip, 3'b0};

  assign w_pend_mei = w_meip   & mie[11];
  assign w_pend_msi = irq_msip & mie[3];
  assign w_pend_mti = irq_mtip & mie[7];
  assign w_take     = (w_pend_mei | w_pend_msi | w_pend_mti) & mstatus_mie & instr_bound;
  assign w_code     = irq_pick(w_pend_mei, w_pend_msi, w_pend_mti);

  assign w_unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

  state_t      r_state;
  logic        r_trap_req;
  logic [31:0] r_cause;
  logic        r_busy;
  logic [CW-1:0] r_hold_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_trap_req <= 1'b0;
      r_cause    <= '0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_state    <= ST_REQ;
            r_trap_req <= 1'b1;
            r_cause    <= mcause_of(w_code);
            r_busy     <= 1'b1;
          end
        end
        // The request is never withdrawn; cause stays frozen until the handler returns.
        ST_REQ: begin
          if (trap_ack) begin
            r_state    <= ST_ACTIVE;
            r_trap_req <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (mret) begin
            if (HOLDOFF_CYCLES == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_cause <= '0;
            end else begin
              r_state    <= ST_HOLDOFF;
              r_hold_cnt <= HOLD_LOAD;
            end
          end
        end
        ST_HOLDOFF: begin
          r_cause <= '0;
          if (r_hold_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_trap_req <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign trap_req   = r_trap_req;
  assign trap_cause = r_cause;
  assign busy       = r_busy;

endmodule
